mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register: accepts one EX/MEM bundle per transaction.
- Performs the data-memory access over a req/ack bus, stalling upstream while the access is in flight.
- Drives the MEM/WB register outputs (WB controls, read data, ALU result, destination register) into the writeback stage.
- Also resolves the branch decision (PCSrc) for the fetch stage.

Parameters:
- ADDR_W, 32, data-memory address width; taken from ALUOut[ADDR_W-1:0].
- DATA_W, 32, data width of ALUOut, WriteDataIn, mem_wdata and mem_rdata.
- TIMEOUT, 16, cycles in WAIT_ACK without mem_ack before the access is aborted.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM bundle present this cycle.
- in_ready  out  1  stage can accept a bundle; 0 stalls EX/MEM.
- WB  in  2  [1]=RegWrite, [0]=MemtoReg.
- M  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- Zero  in  1  ALU zero flag from EX/MEM.
- ALUOut  in  DATA_W  ALU result / memory address.
- WriteDataIn  in  DATA_W  store data.
- RegRD  in  5  destination register.
- PCSrc  out  1  combinational: in_valid & in_ready & M[2] & Zero.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  access complete.
- out_valid  out  1  one-cycle pulse: MEM/WB outputs updated.
- WBreg  out  2  registered WB controls.
- ReadDataReg  out  DATA_W  registered load data.
- ALUreg  out  DATA_W  registered ALUOut.
- RegRDreg  out  5  registered RegRD.
- mem_err  out  1  registered error flag for the bundle in MEM/WB.

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - All outputs 0 except in_ready=1; mem_req drops immediately.
  - FSM goes to IDLE, timeout counter cleared.
  - An in-flight access is abandoned; a late mem_ack is ignored.
- States: IDLE, WAIT_ACK. in_ready=1 only in IDLE.
- Accept = in_valid & in_ready, sampled at the rising edge. in_valid while in_ready=0 is ignored; the producer holds the bundle.
- No memory op (M[1:0]=00):
  - Next edge: out_valid=1.
  - WBreg=WB, ALUreg=ALUOut, RegRDreg=RegRD, ReadDataReg=0, mem_err=0.
  - Latency 1, stay in IDLE.
- Illegal op (M[1:0]=11), or misaligned (ALUOut[1:0]!=0 with a memory op):
  - No bus access.
  - Next edge: out_valid=1, mem_err=1, WBreg[1] forced 0, WBreg[0] as WB[0].
- Legal memory op:
  - Next edge: capture the bundle, enter WAIT_ACK, assert mem_req.
  - mem_we=M[0], mem_addr=ALUOut[ADDR_W-1:0], mem_wdata=WriteDataIn; all stable while mem_req=1.
- WAIT_ACK, mem_ack=1 at an edge:
  - mem_req deasserts after that edge.
  - out_valid=1 with the captured bundle. Reads: ReadDataReg=mem_rdata. Writes: ReadDataReg=0.
  - Back to IDLE. Minimum latency: accept edge + ack edge = 2 cycles.
- mem_ack while mem_req=0 is ignored.
- Timeout:
  - Counter clears on entry to WAIT_ACK and increments each cycle without ack.
  - When it reaches TIMEOUT-1 without ack: mem_req drops; out_valid=1, mem_err=1, WBreg[1]=0; back to IDLE.
  - mem_ack on that same edge wins: normal completion, no error.
- out_valid lasts one cycle only. WBreg/ALUreg/RegRDreg/ReadDataReg/mem_err hold until the next out_valid. Writeback never back-pressures.
- Back-to-back no-op bundles: one per cycle, out_valid continuously high.

Decomposition:
- Shared package pipe_pkg:
  - WB bit indices WB_REGWRITE=1, WB_MEMTOREG=0.
  - M bit indices M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0.
  - state encoding IDLE/WAIT_ACK.
- One sub-module: mem_timeout_cnt (clear, enable, expired output, width clog2(TIMEOUT)).

Test Plan:
- Reset: assert rst mid-WAIT_ACK -> mem_req=0 and in_ready=1 immediately; outputs 0; ack 2 cycles later produces no out_valid.
- ALU op, no memory: WB=2'b10, M=0, ALUOut=100, RegRD=5, in_valid=1 -> next cycle out_valid=1, WBreg=2, ALUreg=100, RegRDreg=5, mem_err=0.
- Load: M=3'b010, ALUOut=100, ack after 3 cycles with mem_rdata=0xCAFE -> in_ready=0 for 4 cycles; mem_addr=100, mem_we=0; out_valid with ReadDataReg=0xCAFE.
- Store: M=3'b001, ALUOut=100, WriteDataIn=150, ack the next cycle -> mem_we=1, mem_wdata=150; out_valid with ReadDataReg=0.
- Errors:
  - ALUOut=102 with a load -> no mem_req, mem_err=1, WBreg[1]=0.
  - Load never acked, TIMEOUT=16 -> mem_req drops after 16 cycles, mem_err=1.
- Branch: M=3'b100, Zero=1, in_valid=1 -> PCSrc=1 same cycle; Zero=0 -> PCSrc=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the memory stage.
//   - WB / M control-field bit positions of the EX/MEM bundle
//   - memory-stage FSM state encoding
//   - captured-bundle struct and the access legality helper
package pipe_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_e;

    // Control part of a bundle held across a bus access.
    typedef struct packed {
        logic [1:0] wb;
        logic [4:0] rd;
    } mem_bundle_t;

    // Exactly one of MemRead/MemWrite set and a word-aligned address.
    function automatic logic access_ok(input logic [1:0] m_rw, input logic [1:0] addr_lo);
        return (m_rw[M_MEMREAD] ^ m_rw[M_MEMWRITE]) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus-access timeout counter.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart from 0 (access issued)
//   enable    : count one cycle without acknowledge
//   expired   : counter sits at TIMEOUT-1
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT - 1));

    // Saturates at TIMEOUT-1; the FSM leaves WAIT_ACK on that edge anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller.
//   Consumes EX/MEM bundles (in_valid/in_ready), performs the data-memory
//   access over a req/ack bus with a timeout, drives the MEM/WB register
//   outputs and resolves PCSrc combinationally for fetch.
//   Inputs : in_valid, WB, M, Zero, ALUOut, WriteDataIn, RegRD, mem_rdata, mem_ack
//   Outputs: in_ready, PCSrc, mem_req/we/addr/wdata, out_valid, WBreg,
//            ReadDataReg, ALUreg, RegRDreg, mem_err
import pipe_pkg::*;

module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        WB,
    input  logic [2:0]        M,
    input  logic              Zero,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic [4:0]        RegRD,
    output logic              PCSrc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [1:0]        WBreg,
    output logic [DATA_W-1:0] ReadDataReg,
    output logic [DATA_W-1:0] ALUreg,
    output logic [4:0]        RegRDreg,
    output logic              mem_err
);

    mem_state_e         state_q, state_d;
    mem_bundle_t        cap;
    logic [DATA_W-1:0]  cap_alu;

    logic accept, memop, legal, expired;
    logic issue, fin_noop, fin_err, fin_ack, fin_tmo;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign PCSrc    = accept & M[M_BRANCH] & Zero;
    assign memop    = M[M_MEMREAD] | M[M_MEMWRITE];
    assign legal    = access_ok(M[1:0], ALUOut[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        fin_noop = 1'b0;
        fin_err  = 1'b0;
        fin_ack  = 1'b0;
        fin_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!memop)
                        fin_noop = 1'b1;
                    else if (!legal)
                        fin_err = 1'b1;
                    else begin
                        issue   = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // An ack on the expiry edge still completes normally.
                if (mem_ack) begin
                    fin_ack = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    fin_tmo = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (issue),
        .enable  ((state_q == WAIT_ACK) & ~mem_ack),
        .expired (expired)
    );

    // Bus side: request and its qualifiers are registered so they stay
    // stable for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cap       <= '0;
            cap_alu   <= '0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= M[M_MEMWRITE];
            mem_addr  <= ALUOut[ADDR_W-1:0];
            mem_wdata <= WriteDataIn;
            cap       <= '{wb: WB, rd: RegRD};
            cap_alu   <= ALUOut;
        end else if (fin_ack || fin_tmo) begin
            mem_req   <= 1'b0;
        end
    end

    // MEM/WB side: updated only alongside an out_valid pulse, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            WBreg       <= '0;
            ReadDataReg <= '0;
            ALUreg      <= '0;
            RegRDreg    <= '0;
            mem_err     <= 1'b0;
        end else begin
            out_valid <= fin_noop | fin_err | fin_ack | fin_tmo;
            if (fin_noop || fin_err) begin
                // Errored bundles must not write the register file.
                WBreg       <= {WB[WB_REGWRITE] & fin_noop, WB[WB_MEMTOREG]};
                ALUreg      <= ALUOut;
                RegRDreg    <= RegRD;
                ReadDataReg <= '0;
                mem_err     <= fin_err;
            end else if (fin_ack) begin
                WBreg       <= cap.wb;
                ALUreg      <= cap_alu;
                RegRDreg    <= cap.rd;
                ReadDataReg <= mem_we ? '0 : mem_rdata;
                mem_err     <= 1'b0;
            end else if (fin_tmo) begin
                WBreg       <= {1'b0, cap.wb[WB_MEMTOREG]};
                ALUreg      <= cap_alu;
                RegRDreg    <= cap.rd;
                ReadDataReg <= '0;
                mem_err     <= 1'b1;
            end
        end
    end

endmodule
